// File: rtl/pb_debounce.sv
// Push-button conditioner: 2-flop sync, per-bit debounce filter, press/release pulses, sticky event flags.
// Optional auto-repeat of press_pulse on held buttons is compiled in with `define PB_AUTOREPEAT_EN.
module pb_debounce #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic             clkin_50,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pb_raw,
   output logic [WIDTH-1:0] pb_level,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse,
   output logic [WIDTH-1:0] event_flag,
   input  logic [WIDTH-1:0] event_ack,
   output logic             any_event
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [WIDTH-1:0] RELEASED = {WIDTH{ACTIVE_LOW}};

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] pressed;
   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] press_acc;
   logic [WIDTH-1:0] release_acc;
   logic [WIDTH-1:0] rpt_fire;

   always_ff @(posedge clkin_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= RELEASED;
         sync2 <= RELEASED;
      end else begin
         sync1 <= pb_raw;
         sync2 <= sync1;
      end
   end

   assign pressed = sync2 ^ RELEASED;

   // Each bit counts consecutive samples that disagree with its accepted level.
   for (genvar i = 0; i < WIDTH; i++) begin : g_filter
      logic [CW-1:0] cnt;
      logic          differ;

      assign differ    = pressed[i] != pb_level[i];
      assign accept[i] = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));

      always_ff @(posedge clkin_50 or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
         end else if (!differ || accept[i]) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign press_acc   = accept & ~pb_level;
   assign release_acc = accept & pb_level;

`ifdef PB_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

   // Down-counter per bit: loaded with the initial delay on press, reloaded with the period on each repeat.
   for (genvar i = 0; i < WIDTH; i++) begin : g_repeat
      logic [RW-1:0] rpt_cnt;

      assign rpt_fire[i] = pb_level[i] && !accept[i] && (rpt_cnt == '0);

      always_ff @(posedge clkin_50 or negedge rst_n) begin
         if (!rst_n) begin
            rpt_cnt <= '0;
         end else if (press_acc[i]) begin
            rpt_cnt <= RW'(REPEAT_DELAY - 1);
         end else if (!pb_level[i] || accept[i]) begin
            rpt_cnt <= '0;
         end else if (rpt_fire[i]) begin
            rpt_cnt <= RW'(REPEAT_PERIOD - 1);
         end else begin
            rpt_cnt <= rpt_cnt - RW'(1);
         end
      end
   end
`else
   assign rpt_fire = '0;
`endif

   always_ff @(posedge clkin_50 or negedge rst_n) begin
      if (!rst_n) begin
         pb_level      <= '0;
         press_pulse   <= '0;
         release_pulse <= '0;
         event_flag    <= '0;
         any_event     <= 1'b0;
      end else begin
         pb_level      <= pb_level ^ accept;
         press_pulse   <= press_acc | rpt_fire;
         release_pulse <= release_acc;
         // A pulse landing together with its ack wins, so no event is lost.
         event_flag    <= press_pulse | (event_flag & ~event_ack);
         any_event     <= |event_flag;
      end
   end

endmodule

// File: tb/tb_pb_debounce.sv
// Self-checking bench for pb_debounce: cycle-level behavioural model plus directed, hand-computed checks.
// Build with `define PB_AUTOREPEAT_EN to exercise the auto-repeat expectations.
module tb_pb_debounce;

   localparam int W  = 4;
   localparam int DC = 8;
   localparam int RD = 20;
   localparam int RP = 6;

   logic         clkin_50 = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] pb_raw = 4'hF;
   logic [W-1:0] event_ack = 4'h0;
   logic [W-1:0] pb_level, press_pulse, release_pulse, event_flag;
   logic         any_event;

   int vectors = 0;
   int miscompares = 0;
   bit done = 1'b0;

   pb_debounce #(
      .WIDTH(W), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clkin_50(clkin_50), .rst_n(rst_n), .pb_raw(pb_raw),
      .pb_level(pb_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
      .event_flag(event_flag), .event_ack(event_ack), .any_event(any_event)
   );

   always #5 clkin_50 = ~clkin_50;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a level is accepted after DC consecutive synchronised samples disagree with it.
   logic [W-1:0] m_d1, m_d2, m_level, m_press, m_rel, m_flag;
   logic         m_any;
   int           run  [W];
   int           hold [W];

   function automatic void m_reset();
      m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_flag = '0; m_any = 1'b0;
      for (int i = 0; i < W; i++) begin
         run[i] = 0;
         hold[i] = 0;
      end
   endfunction

   function automatic void m_step();
      logic [W-1:0] np, nr;
      logic         new_any;
      logic [W-1:0] new_flag;
      new_any  = |m_flag;
      new_flag = m_press | (m_flag & ~event_ack);
      np = '0;
      nr = '0;
      for (int i = 0; i < W; i++) begin
         if (m_d2[i] != m_level[i]) run[i]++;
         else run[i] = 0;
         if (run[i] == DC) begin
            run[i] = 0;
            if (!m_level[i]) begin
               np[i] = 1'b1;
               hold[i] = 0;
            end else begin
               nr[i] = 1'b1;
            end
            m_level[i] = ~m_level[i];
         end else if (m_level[i]) begin
            hold[i]++;
`ifdef PB_AUTOREPEAT_EN
            if (hold[i] >= RD && ((hold[i] - RD) % RP) == 0) np[i] = 1'b1;
`endif
         end
      end
      m_d2 = m_d1;
      m_d1 = ~pb_raw;
      m_press = np;
      m_rel = nr;
      m_flag = new_flag;
      m_any = new_any;
   endfunction

   initial begin
      m_reset();
      forever begin
         @(posedge clkin_50 or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   initial begin
      while (!done) begin
         @(negedge clkin_50);
         #1;
         if (done) break;
         check("pb_level", pb_level, m_level);
         check("press_pulse", press_pulse, m_press);
         check("release_pulse", release_pulse, m_rel);
         check("event_flag", event_flag, m_flag);
         check("any_event", any_event, m_any);
      end
   end

   // Returns edges counted from the first sampling edge until the selected pulse appears (0 on timeout).
   task automatic wait_pulse(input int idx, input bit rel, output int n);
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clkin_50);
         #1;
         if ((rel ? release_pulse[idx] : press_pulse[idx]) === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clkin_50);
   endtask

   int n;
   int idx;
   int exp_rpt[$];

   initial begin
      cycles(3);
      check("reset_level", pb_level, 0);
      check("reset_press", press_pulse, 0);
      check("reset_release", release_pulse, 0);
      check("reset_flag", event_flag, 0);
      check("reset_any", any_event, 0);
      rst_n = 1'b1;
      cycles(3);

      // single press on bit 0
      pb_raw[0] = 1'b0;
      wait_pulse(0, 1'b0, n);
      check("press0_latency", n, 10);
      check("press0_level", pb_level[0], 1);
      check("model_press0", m_press[0], 1);
      @(posedge clkin_50); #1;
      check("press0_onecycle", press_pulse[0], 0);
      check("flag0_set", event_flag[0], 1);
      @(posedge clkin_50); #1;
      check("any_event_set", any_event, 1);

      // bounce on bit 1: never DC stable samples
      @(negedge clkin_50);
      pb_raw[1] = 1'b0; cycles(5);
      pb_raw[1] = 1'b1; cycles(1);
      pb_raw[1] = 1'b0; cycles(5);
      pb_raw[1] = 1'b1; cycles(12);
      check("bounce_level", pb_level[1], 0);
      check("model_bounce_level", m_level[1], 0);
      pb_raw[1] = 1'b0;
      wait_pulse(1, 1'b0, n);
      check("press1_latency", n, 10);

      // release bit 0
      @(negedge clkin_50);
      pb_raw[0] = 1'b1;
      wait_pulse(0, 1'b1, n);
      check("release0_latency", n, 10);
      check("release0_level", pb_level[0], 0);
      check("release0_flag_kept", event_flag[0], 1);
      @(posedge clkin_50); #1;
      check("release0_onecycle", release_pulse[0], 0);

      // ack alone, then ack colliding with a new press
      @(negedge clkin_50); event_ack = 4'h1;
      @(posedge clkin_50); #1;
      check("ack_clears", event_flag[0], 0);
      @(negedge clkin_50); event_ack = 4'h0;
      pb_raw[0] = 1'b0;
      wait_pulse(0, 1'b0, n);
      check("press0b_latency", n, 10);
      @(negedge clkin_50); event_ack = 4'h1;
      @(posedge clkin_50); #1;
      check("set_beats_ack", event_flag[0], 1);
      @(posedge clkin_50); #1;
      check("ack_next_cycle", event_flag[0], 0);
      @(negedge clkin_50); event_ack = 4'h0;
      pb_raw[0] = 1'b1;
      cycles(12);

      // all four together
      pb_raw = 4'hF; cycles(12);
      pb_raw = 4'h0;
      wait_pulse(0, 1'b0, n);
      check("all_latency", n, 10);
      check("all_press", press_pulse, 4'hF);
      @(negedge clkin_50);
      pb_raw = 4'hF; cycles(12);

      // reset mid-count with all buttons held
      pb_raw = 4'h0; cycles(5);
      rst_n = 1'b0;
      #1;
      check("midrst_level", pb_level, 0);
      check("midrst_press", press_pulse, 0);
      check("midrst_flag", event_flag, 0);
      check("midrst_any", any_event, 0);
      cycles(3);
      rst_n = 1'b1;
      wait_pulse(0, 1'b0, n);
      check("post_reset_latency", n, 10);
      check("post_reset_press", press_pulse, 4'hF);
      @(negedge clkin_50);
      pb_raw = 4'hF; cycles(12);

      // hold bit 2 for 60 cycles after acceptance
`ifdef PB_AUTOREPEAT_EN
      exp_rpt = '{20, 26, 32, 38, 44, 50, 56};
`endif
      pb_raw[2] = 1'b0;
      wait_pulse(2, 1'b0, n);
      check("hold2_latency", n, 10);
      idx = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clkin_50); #1;
         if (press_pulse[2] === 1'b1) begin
            if (idx < exp_rpt.size()) check("repeat_offset", k, exp_rpt[idx]);
            else check("repeat_extra", k, 0);
            idx++;
         end
      end
      check("repeat_count", idx, exp_rpt.size());
      @(negedge clkin_50);
      pb_raw = 4'hF; cycles(14);

      done = 1'b1;
      cycles(1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
